// File: rtl/muldiv_ctrl_if.sv
// ============================================================================
// Module      : muldiv_ctrl_if
// Description : Issue/result bundle between the core and the HI/LO
//               multiply/divide controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_ctrl_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivZero;

  // Core side issues operations and reads the architectural registers.
  modport master (output Start, Op, A, B, Flush, input Busy, HI, LO, DivZero);
  // Unit side accepts operations and owns HI/LO.
  modport slave  (input Start, Op, A, B, Flush, output Busy, HI, LO, DivZero);
endinterface

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module      : muldiv_ctrl
// Description : HI/LO multiply/divide controller. Multiplies occupy the unit
//               for 5 cycles, divides for 10; mthi/mtlo write immediately.
//               Optional multiply-accumulate (madd/maddu) is built only when
//               the macro MULDIV_MADD_EN is defined; otherwise those opcodes
//               are no-ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl (
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  // Counter value during the final busy cycle of each operation class.
  localparam logic [3:0] MUL_LAST = 4'd4;
  localparam logic [3:0] DIV_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic        div_zero, div_zero_nxt;

  // Latched operands and operation flavour for the multi-cycle ops.
  logic [31:0] opa, opb;
  logic        op_signed, op_acc;
  logic        load, load_acc;

  // Multiply datapath: 64-bit product of sign- or zero-extended operands;
  // the low 64 bits are correct for both signed and unsigned forms.
  logic [63:0] ext_a, ext_b, product, mul_result;

  assign ext_a      = {{32{op_signed & opa[31]}}, opa};
  assign ext_b      = {{32{op_signed & opb[31]}}, opb};
  assign product    = ext_a * ext_b;
  assign mul_result = op_acc ? ({hi, lo} + product) : product;

  // Divide datapath: divide magnitudes, then restore signs. Working on
  // magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to
  // 0x80000000, remainder 0). A zero divisor is replaced by 1 so the
  // datapath never sees x/0; the result is discarded in that case anyway.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, den, uquot, urem, quot, rem;

  assign neg_a = op_signed & opa[31];
  assign neg_b = op_signed & opb[31];
  assign mag_a = neg_a ? (~opa + 32'd1) : opa;
  assign mag_b = neg_b ? (~opb + 32'd1) : opb;
  assign den   = (opb == 32'd0) ? 32'd1 : mag_b;
  assign uquot = mag_a / den;
  assign urem  = mag_a % den;
  assign quot  = (neg_a ^ neg_b) ? (~uquot + 32'd1) : uquot;
  assign rem   = neg_a ? (~urem + 32'd1) : urem;

  // Next-state, counter and HI/LO write decisions; Flush beats everything.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hi_nxt       = hi;
    lo_nxt       = lo;
    div_zero_nxt = 1'b0;
    load         = 1'b0;
    load_acc     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.Flush && bus.Start) begin
          case (bus.Op)
            OP_MTHI: hi_nxt = bus.A;
            OP_MTLO: lo_nxt = bus.A;
            OP_MULT, OP_MULTU: begin
              state_nxt = MUL;
              cnt_nxt   = 4'd0;
              load      = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_nxt = DIV;
              cnt_nxt   = 4'd0;
              load      = 1'b1;
            end
            OP_MADD, OP_MADDU: begin
`ifdef MULDIV_MADD_EN
              state_nxt = MUL;
              cnt_nxt   = 4'd0;
              load      = 1'b1;
              load_acc  = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (bus.Flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == MUL_LAST) begin
          state_nxt        = IDLE;
          cnt_nxt          = 4'd0;
          {hi_nxt, lo_nxt} = mul_result;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DIV: begin
        if (bus.Flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == DIV_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          if (opb == 32'd0) begin
            div_zero_nxt = 1'b1;
          end else begin
            hi_nxt = rem;
            lo_nxt = quot;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Control state register and cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Architectural HI/LO and the divide-by-zero completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  // Operand capture, only when a multi-cycle op is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa       <= 32'd0;
      opb       <= 32'd0;
      op_signed <= 1'b0;
      op_acc    <= 1'b0;
    end else if (load) begin
      opa       <= bus.A;
      opb       <= bus.B;
      op_signed <= ~bus.Op[0];
      op_acc    <= load_acc;
    end
  end

  assign bus.Busy    = (state != IDLE);
  assign bus.HI      = hi;
  assign bus.LO      = lo;
  assign bus.DivZero = div_zero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl: directed corner cases
//               followed by randomized operations, flushes and resets.
//               Honours MULDIV_MADD_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observable state for one cycle, sampled at that cycle's negedge.
  typedef struct {
    int          cyc;
    bit          busy;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due this cycle and compare.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc || bus.Busy !== e.busy || bus.HI !== e.hi ||
          bus.LO !== e.lo || bus.DivZero !== e.dz) begin
        miscompares++;
        $display("FAIL state@cyc%0d (due %0d): got busy=%b hi=%h lo=%h dz=%b, want busy=%b hi=%h lo=%h dz=%b",
                 cyc, e.cyc, bus.Busy, bus.HI, bus.LO, bus.DivZero, e.busy, e.hi, e.lo, e.dz);
      end
    end
  end

  task automatic push(input int c, input bit busy, input logic [31:0] hi,
                      input logic [31:0] lo, input bit dz);
    exp_t e;
    e.cyc = c; e.busy = busy; e.hi = hi; e.lo = lo; e.dz = dz;
    q.push_back(e);
  endtask

  // Issue one operation from IDLE. intr/fl/rs give the busy cycle (1-based)
  // in which a stray Start, a Flush or a reset is driven (0 = none);
  // fl0 raises Flush together with Start.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int intr, input int fl,
                        input int rs, input bit fl0);
    int          n, len, stop;
    bit          abort, dz;
    longint      sa, sb, q64, r64;
    logic [63:0] res;
    logic [31:0] old_hi, old_lo, new_hi, new_lo;
    n = cyc;
    old_hi = m_hi; old_lo = m_lo; new_hi = m_hi; new_lo = m_lo;
    dz = 1'b0; len = 0;
    sa = $signed(a);
    sb = $signed(b);
    if (!fl0) begin
      case (op)
        3'b000: begin len = 5; res = sa * sb; {new_hi, new_lo} = res; end
        3'b001: begin len = 5; res = {32'd0, a} * {32'd0, b}; {new_hi, new_lo} = res; end
        3'b010: begin
          len = 10;
          if (b == 32'd0) dz = 1'b1;
          else begin
            q64 = sa / sb; r64 = sa % sb;
            new_lo = q64[31:0]; new_hi = r64[31:0];
          end
        end
        3'b011: begin
          len = 10;
          if (b == 32'd0) dz = 1'b1;
          else begin new_lo = a / b; new_hi = a % b; end
        end
        3'b100: if (MADD_EN) begin len = 5; res = sa * sb; {new_hi, new_lo} = {m_hi, m_lo} + res; end
        3'b101: if (MADD_EN) begin len = 5; res = {32'd0, a} * {32'd0, b}; {new_hi, new_lo} = {m_hi, m_lo} + res; end
        3'b110: new_hi = a;
        default: new_lo = a;
      endcase
    end
    stop = len; abort = 1'b0;
    if (fl > 0 && fl <= len) begin stop = fl; abort = 1'b1; end
    if (rs > 0 && rs <= len) begin stop = rs; abort = 1'b1; end
    for (int i = 1; i <= stop; i++) push(n + i, 1'b1, old_hi, old_lo, 1'b0);
    if (abort) begin
      if (rs > 0 && rs <= len) begin m_hi = 32'd0; m_lo = 32'd0; end
      push(n + stop + 1, 1'b0, m_hi, m_lo, 1'b0);
    end else begin
      m_hi = new_hi; m_lo = new_lo;
      push(n + len + 1, 1'b0, m_hi, m_lo, dz);
      if (dz) push(n + len + 2, 1'b0, m_hi, m_lo, 1'b0);
    end
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b; bus.Flush = fl0;
    @(posedge clk) #1;
    bus.Start = 1'b0; bus.Flush = 1'b0;
    for (int i = 1; i <= stop; i++) begin
      if (i == intr) begin
        bus.Start = 1'b1; bus.Op = 3'($urandom); bus.A = $urandom; bus.B = $urandom;
      end
      if (i == fl) bus.Flush = 1'b1;
      if (i == rs) reset = 1'b1;
      @(posedge clk) #1;
      bus.Start = 1'b0; bus.Flush = 1'b0; reset = 1'b0;
    end
    if (!abort && dz) @(posedge clk) #1;
  endtask

  // Idle cycles: HI/LO must hold and Busy stay low.
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      push(cyc, 1'b0, m_hi, m_lo, 1'b0);
      @(posedge clk) #1;
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(7, 0))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int sel, w;
    reset = 1'b1;
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = 3'b000;
    bus.A = 32'd5; bus.B = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, 1'b0, 32'd0, 32'd0, 1'b0);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    @(posedge clk) #1;
    reset = 1'b0;
    idle(1);

    // Directed corner cases.
    run_op(3'b110, 32'h1234_5678, 32'd0, 0, 0, 0, 1'b0);
    run_op(3'b100, 32'd2, 32'd3, 0, 0, 0, 1'b0);
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 1'b0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1'b0);
    run_op(3'b011, 32'd7, 32'd0, 0, 0, 0, 1'b0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    run_op(3'b000, 32'd11, 32'd13, 2, 0, 0, 1'b0);
    run_op(3'b010, 32'd100, 32'd7, 0, 3, 0, 1'b0);
    idle(1);
    run_op(3'b000, 32'd9, 32'd9, 0, 0, 0, 1'b1);
    run_op(3'b111, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, 1'b1);
    run_op(3'b000, 32'd6, 32'd7, 0, 0, 2, 1'b0);
    idle(1);

    // Randomized operations with occasional disruptions.
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(19, 0);
      w   = $urandom_range(10, 1);
      case (sel)
        0, 1:    run_op(3'($urandom), rnd32(), rnd32(), w, 0, 0, 1'b0);
        2:       run_op(3'($urandom), rnd32(), rnd32(), 0, w, 0, 1'b0);
        3:       run_op(3'($urandom), rnd32(), rnd32(), 0, 0, w, 1'b0);
        4:       run_op(3'($urandom), rnd32(), rnd32(), 0, 0, 0, 1'b1);
        default: run_op(3'($urandom), rnd32(), rnd32(), 0, 0, 0, 1'b0);
      endcase
      idle($urandom_range(2, 0));
    end

    for (int t = 0; t < 100 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk) #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
